// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx serial transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int PISO_W_DEFAULT = 8;

endpackage

// File: rtl/piso_shreg.sv
// Shift register and bit counter for piso_tx.
// Drives the serial bit and flags the last bit of a word.
module piso_shreg
    import piso_pkg::*;
#(
    parameter int W = PISO_W_DEFAULT
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         load,
    input  logic [W-1:0] load_word,
    input  logic         shift,
    input  logic         clr,
    input  logic         active,
    output logic         so,
    output logic         so_last,
    output logic         cnt_last
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;

    // Load has priority; clearing sreg on an idle return keeps so low without extra gating.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_word;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= {sreg[W-2:0], 1'b0};
            cnt  <= cnt + 1'b1;
        end else if (clr) begin
            sreg <= '0;
            cnt  <= '0;
        end
    end

    assign cnt_last = (cnt == CNT_MAX);
    assign so       = sreg[W-1];
    assign so_last  = active && cnt_last;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter with a one-word holding register.
// Words stream MSB first with no gap when the next word is already held.
module piso_tx
    import piso_pkg::*;
#(
    parameter int W = PISO_W_DEFAULT
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic [W-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         so,
    output logic         so_valid,
    output logic         so_last,
    output logic         busy
);

    piso_state_t  state;
    logic [W-1:0] hold;
    logic         hold_full;
    logic         cnt_last;
    logic         accept;
    logic         xfer;
    logic         shifting;

    assign shifting = (state == SHIFT);
    assign accept   = load_valid && !hold_full;
    // A held word moves into the shifter when idle or exactly as the previous word ends.
    assign xfer     = hold_full && (!shifting || cnt_last);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (xfer) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else if (xfer) begin
            state <= SHIFT;
        end else if (shifting && cnt_last) begin
            state <= IDLE;
        end
    end

    piso_shreg #(.W(W)) u_shreg (
        .clk       (clk),
        .clear_n   (clear_n),
        .load      (xfer),
        .load_word (hold),
        .shift     (shifting && !cnt_last),
        .clr       (shifting && cnt_last && !hold_full),
        .active    (shifting),
        .so        (so),
        .so_last   (so_last),
        .cnt_last  (cnt_last)
    );

    assign load_ready = !hold_full;
    assign so_valid   = shifting;
    assign busy       = shifting || hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: cycle tables for single and back-to-back words,
// plus hand-written reset, backpressure and gap sequences.
module tb_piso_tx;

    logic       clk;
    logic       clear_n;
    logic [7:0] din;
    logic       load_valid;
    logic       load_ready;
    logic       so;
    logic       so_valid;
    logic       so_last;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       lv;
        logic [7:0] d;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    piso_tx #(.W(8)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .so         (so),
        .so_valid   (so_valid),
        .so_last    (so_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {so, so_valid, so_last, busy, load_ready};
    endfunction

    function automatic void addRow(logic lv, logic [7:0] d, logic [4:0] exp);
        vec_t v;
        v.lv  = lv;
        v.d   = d;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(string name, logic [23:0] act, logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one row before an edge, then compare outputs just after it.
    task automatic applyStimulus(int idx);
        load_valid = vecs[idx].lv;
        din        = vecs[idx].d;
        @(posedge clk);
        #1;
        checkOutput($sformatf("row%0d", idx), {19'd0, outs()}, {19'd0, vecs[idx].exp});
    endtask

    task automatic sendWord(logic [7:0] w);
        load_valid = 1'b1;
        din        = w;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic collectWord(output logic [7:0] bits, output logic [7:0] lastMask,
                               output logic [7:0] validMask, output int waitCycles);
        waitCycles = 0;
        bits = '0;
        lastMask = '0;
        validMask = '0;
        while (!so_valid && waitCycles < 20) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (so_valid) begin
            for (int i = 7; i >= 0; i--) begin
                bits[i]      = so;
                lastMask[i]  = so_last;
                validMask[i] = so_valid;
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic backpressureTest();
        logic [23:0] words;
        logic [23:0] got;
        logic        rdy;
        logic        started;
        int idx, nbits, lasts, gaps, cyc, badReady;
        words = 24'h965AE1;
        got = '0;
        started = 1'b0;
        idx = 0; nbits = 0; lasts = 0; gaps = 0; cyc = 0; badReady = 0;
        while (nbits < 24 && cyc < 100) begin
            if (idx < 3) begin
                load_valid = 1'b1;
                din        = words[23 - 8*idx -: 8];
            end else begin
                load_valid = 1'b0;
            end
            rdy = load_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (load_valid && rdy) begin
                idx++;
                if (load_ready) badReady++;
            end
            if (so_valid) begin
                got[23 - nbits] = so;
                nbits++;
                started = 1'b1;
                if (so_last) lasts++;
            end else if (started) begin
                gaps++;
            end
        end
        load_valid = 1'b0;
        checkOutput("bp_bits", got, words);
        checkOutput("bp_accepts", 24'(idx), 24'd3);
        checkOutput("bp_last_count", 24'(lasts), 24'd3);
        checkOutput("bp_gaps", 24'(gaps), 24'd0);
        checkOutput("bp_ready_after_accept", 24'(badReady), 24'd0);
        @(posedge clk);
        #1;
        checkOutput("bp_idle", {19'd0, outs()}, 24'b00001);
    endtask

    initial begin
        logic [7:0] bits, lastMask, validMask;
        int waitCycles;
        int strayValid;

        clear_n    = 1'b0;
        load_valid = 1'b1;
        din        = 8'hFF;
        #3;
        checkOutput("reset_outputs", {19'd0, outs()}, 24'b00001);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_no_accept", {19'd0, outs()}, 24'b00001);
        load_valid = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_release_idle", {19'd0, outs()}, 24'b00001);

        // Single 8'hA5 followed by back-to-back 8'hF0 / 8'h0F; exp = {so,so_valid,so_last,busy,load_ready}.
        addRow(1, 8'hA5, 5'b00010);
        addRow(0, 8'h00, 5'b11011);
        addRow(0, 8'h00, 5'b01011);
        addRow(0, 8'h00, 5'b11011);
        addRow(0, 8'h00, 5'b01011);
        addRow(0, 8'h00, 5'b01011);
        addRow(0, 8'h00, 5'b11011);
        addRow(0, 8'h00, 5'b01011);
        addRow(0, 8'h00, 5'b11111);
        addRow(0, 8'h00, 5'b00001);
        addRow(1, 8'hF0, 5'b00010);
        addRow(1, 8'h0F, 5'b11011);
        addRow(1, 8'h0F, 5'b11010);
        addRow(0, 8'h00, 5'b11010);
        addRow(0, 8'h00, 5'b11010);
        addRow(0, 8'h00, 5'b01010);
        addRow(0, 8'h00, 5'b01010);
        addRow(0, 8'h00, 5'b01010);
        addRow(0, 8'h00, 5'b01110);
        addRow(0, 8'h00, 5'b01011);
        addRow(0, 8'h00, 5'b01011);
        addRow(0, 8'h00, 5'b01011);
        addRow(0, 8'h00, 5'b01011);
        addRow(0, 8'h00, 5'b11011);
        addRow(0, 8'h00, 5'b11011);
        addRow(0, 8'h00, 5'b11011);
        addRow(0, 8'h00, 5'b11111);
        addRow(0, 8'h00, 5'b00001);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i);
        end

        backpressureTest();

        // Abort 8'hFF after three bits, then confirm nothing resumes.
        sendWord(8'hFF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        clear_n = 1'b0;
        #1;
        checkOutput("midword_reset_async", {19'd0, outs()}, 24'b00001);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("midword_reset_hold", {19'd0, outs()}, 24'b00001);
        @(negedge clk);
        clear_n = 1'b1;
        strayValid = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (so_valid || busy) strayValid++;
        end
        checkOutput("midword_no_remainder", 24'(strayValid), 24'd0);
        sendWord(8'h81);
        collectWord(bits, lastMask, validMask, waitCycles);
        checkOutput("word81_bits", {16'd0, bits}, 24'h81);
        checkOutput("word81_last", {16'd0, lastMask}, 24'h01);
        checkOutput("word81_valid", {16'd0, validMask}, 24'hFF);
        checkOutput("word81_latency", 24'(waitCycles), 24'd1);
        @(posedge clk);
        #1;

        // Accept 8'h3C in the last-bit cycle of 8'hC3: expect a single idle cycle.
        sendWord(8'hC3);
        collectWord(bits, lastMask, validMask, waitCycles);
        checkOutput("wordC3_bits", {16'd0, bits}, 24'hC3);
        checkOutput("wordC3_last", {16'd0, lastMask}, 24'h01);
        checkOutput("gap_ready_in_last", {23'd0, load_ready}, 24'd1);
        sendWord(8'h3C);
        checkOutput("gap_idle_cycle", {21'd0, so_valid, busy, load_ready}, 24'b010);
        collectWord(bits, lastMask, validMask, waitCycles);
        checkOutput("gap_length", 24'(waitCycles), 24'd1);
        checkOutput("word3C_bits", {16'd0, bits}, 24'h3C);
        checkOutput("word3C_last", {16'd0, lastMask}, 24'h01);
        checkOutput("word3C_valid", {16'd0, validMask}, 24'hFF);
        @(posedge clk);
        #1;
        checkOutput("final_idle", {19'd0, outs()}, 24'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter for the team's serial shift-register links. It accepts a W-bit word over a valid/ready handshake, buffers one word, and shifts it out MSB first on a single serial line with a qualifying valid and end-of-word marker. The one-entry holding register lets back-to-back words stream without idle cycles. It drives the serial input of downstream shift-register chains.

## Interface
- W, 8, word width in bits; legal range W >= 2.
- clk  input  1  rising-edge clock.
- clear_n  input  1  reset, asynchronous, active-low.
- din  input  W  parallel word to transmit.
- load_valid  input  1  din is valid this cycle.
- load_ready  output  1  holding register empty; a word is accepted when load_valid && load_ready at the rising edge.
- so  output  1  serial data, MSB first; 0 when so_valid is 0.
- so_valid  output  1  so carries a data bit this cycle.
- so_last  output  1  so carries bit 0 (the last bit) of the current word.
- busy  output  1  high while in SHIFT or while the holding register is full.

## Operation
- Storage:
  - hold[W-1:0] and hold_full form the holding register.
  - sreg[W-1:0] is the shift register.
  - cnt counts 0..W-1 and is $clog2(W) bits wide.
  - state is IDLE or SHIFT.
- load_ready = !hold_full. It is combinational from a flop and has no dependency on load_valid.
- Accept: on a rising edge with load_valid && load_ready, hold <= din and hold_full <= 1.
- Transfer from hold into sreg, with sreg <= hold, cnt <= 0, hold_full <= 0 and state <= SHIFT, happens in two cases:
  - In IDLE with hold_full = 1.
  - In SHIFT with cnt == W-1 and hold_full = 1.
- SHIFT with cnt != W-1: sreg <= {sreg[W-2:0],1'b0}, cnt <= cnt+1.
- SHIFT with cnt == W-1 and hold_full = 0: state <= IDLE, sreg <= 0, cnt <= 0.
- Outputs:
  - so = sreg[W-1].
  - so_valid = (state == SHIFT).
  - so_last = so_valid && (cnt == W-1).
  - busy = so_valid || hold_full.
- Accept and transfer never occur on the same edge, because accept requires hold_full = 0 and transfer requires hold_full = 1.
- An accept in the same cycle as a last-bit cycle with hold empty is legal. The word lands in hold, then transfers on the following edge, leaving one idle cycle.
- Arithmetic: cnt wraps only through an explicit reload to 0. cnt never increments past W-1.

## Timing
- Reset (clear_n low, asynchronous, takes effect immediately): state = IDLE, sreg = 0, hold = 0, hold_full = 0, cnt = 0.
  - Resulting outputs: so = 0, so_valid = 0, so_last = 0, busy = 0, load_ready = 1.
  - No accept occurs while clear_n is low.
- Latency: for a word accepted at edge E0 into an idle block:
  - hold_full = 1 after E0.
  - Transfer at E1.
  - MSB is on so with so_valid = 1 in the cycle after E1.
  - Bit 0 with so_last = 1 appears W-1 cycles later.
- Throughput: a second word accepted while the first is shifting follows with zero gap. so_valid stays high continuously, and so_last pulses once per word.
- load_ready falls in the cycle after an accept. It rises in the cycle after the transfer.
- Reset mid-word aborts the current word and any held word immediately. so drops to 0 asynchronously. Nothing is retransmitted after release.
- load_valid may drop without an accept. Data is only captured on a handshake edge.

## Structure
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
  - localparam PISO_W_DEFAULT = 8.
- One natural sub-module, piso_shreg, contains sreg, cnt, the shift/load/clear controls and the so/so_last generation. The top level owns hold, hold_full, the handshake and the state machine.

## Test plan
- Reset: assert clear_n = 0 mid-simulation. Expect so = 0, so_valid = 0, busy = 0, load_ready = 1 immediately, and all of them to hold until release.
- Single word, W = 8: din = 8'hA5 with one load_valid pulse.
  - Two edges later, so_valid is high for exactly 8 cycles.
  - so sequence is 1,0,1,0,0,1,0,1.
  - so_last is high only on the 8th cycle.
  - The block then returns to IDLE.
- Back-to-back words: 8'hF0 then 8'h0F, with load_valid held high.
  - Expect 16 contiguous so_valid cycles carrying 1111000000001111.
  - Expect so_last high on cycles 8 and 16.
  - Expect load_ready low while hold is full.
- Backpressure: hold load_valid high with three words queued. Expect exactly one word in hold at any time and all 24 bits transmitted in order with no word lost or duplicated.
- Reset mid-word: send 8'hFF and pull clear_n low after 3 bits. Expect so = 0 at once and no remainder after release. A following 8'h81 must transmit cleanly as 1,0,0,0,0,0,0,1.
- Gap case: accept 8'h3C exactly in the so_last cycle of a prior 8'hC3. Expect exactly one so_valid = 0 cycle between the two words.
